// File: rtl/vga_sync_generator_pkg.sv
// Shared timing types, default 640x480 mode and small helpers for the VGA sync generator.
package vga_sync_generator_pkg;

    localparam int DEFAULT_COLOR_W = 4;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } vga_timing_t;

    typedef struct packed {
        vga_timing_t h;
        vga_timing_t v;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480 = '{
        h: '{640, 16, 96, 48},
        v: '{480, 10, 2, 33}
    };

    // Width of one colour sample as seen by the output monitor.
    typedef struct packed {
        logic [DEFAULT_COLOR_W-1:0] r;
        logic [DEFAULT_COLOR_W-1:0] g;
        logic [DEFAULT_COLOR_W-1:0] b;
    } rgb_t;

    // One slot of the latency-alignment pipe.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic first;
    } pipe_stage_t;

    function automatic int total(input vga_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_sync_generator_if.sv
// Pixel-request / colour-return bus and VGA pin bundle of the sync generator.
interface vga_sync_generator_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int COLOR_W = 4
);
    logic               pixel_req;
    logic [X_W-1:0]     pixel_x;
    logic [Y_W-1:0]     pixel_y;
    logic [COLOR_W-1:0] src_r;
    logic [COLOR_W-1:0] src_g;
    logic [COLOR_W-1:0] src_b;
    logic               HSync;
    logic               VSync;
    logic [COLOR_W-1:0] RED;
    logic [COLOR_W-1:0] GREEN;
    logic [COLOR_W-1:0] BLUE;
    logic               frame_start;

    modport master (
        output pixel_req, pixel_x, pixel_y,
        output HSync, VSync, RED, GREEN, BLUE, frame_start,
        input  src_r, src_g, src_b
    );

    modport slave (
        input  pixel_req, pixel_x, pixel_y,
        input  HSync, VSync, RED, GREEN, BLUE, frame_start,
        output src_r, src_g, src_b
    );
endinterface

// File: rtl/vga_sync_generator_axis_counter.sv
// One raster axis counter: advances on inc, wraps to 0 after TOTAL-1, idles at 0.
module vga_axis_counter
    import vga_sync_generator_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int TOTAL = 800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);
    assign wrap = (cnt == WIDTH'(TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + WIDTH'(1);
        end
    end
endmodule

// File: rtl/vga_sync_generator.sv
// Parametrised VGA timing engine: pixel-tick divider, H/V raster, pixel requests and
// sync/colour outputs delayed to match the pixel source latency.
module vga_sync_generator
    import vga_sync_generator_pkg::*;
#(
    parameter int COLOR_W  = DEFAULT_COLOR_W,
    parameter int H_ACTIVE = VGA_640x480.h.active,
    parameter int H_FP     = VGA_640x480.h.fp,
    parameter int H_SYNC   = VGA_640x480.h.sync,
    parameter int H_BP     = VGA_640x480.h.bp,
    parameter int V_ACTIVE = VGA_640x480.v.active,
    parameter int V_FP     = VGA_640x480.v.fp,
    parameter int V_SYNC   = VGA_640x480.v.sync,
    parameter int V_BP     = VGA_640x480.v.bp,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 4,
    parameter int PIPE     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    vga_sync_generator_if.master vga
);
    localparam int H_TOT = total(vga_timing_t'{H_ACTIVE, H_FP, H_SYNC, H_BP});
    localparam int V_TOT = total(vga_timing_t'{V_ACTIVE, V_FP, V_SYNC, V_BP});
    localparam int H_W   = width_of(H_TOT);
    localparam int V_W   = width_of(V_TOT);
    localparam int X_W   = width_of(H_ACTIVE);
    localparam int Y_W   = width_of(V_ACTIVE);
    localparam int DIV_W = width_of(CLK_DIV);

    // One spare bit keeps the region bounds exact even when an end equals 2**H_W.
    localparam logic [H_W:0] H_ACT_END = (H_W+1)'(H_ACTIVE);
    localparam logic [H_W:0] HS_START  = (H_W+1)'(H_ACTIVE + H_FP);
    localparam logic [H_W:0] HS_END    = (H_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W:0] V_ACT_END = (V_W+1)'(V_ACTIVE);
    localparam logic [V_W:0] VS_START  = (V_W+1)'(V_ACTIVE + V_FP);
    localparam logic [V_W:0] VS_END    = (V_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]   div;
    logic               tick;
    logic [H_W-1:0]     h;
    logic [V_W-1:0]     v;
    logic               h_wrap;
    logic               v_wrap;
    logic               v_inc;
    logic               at_origin;
    logic               active;
    logic               hs_raw;
    logic               vs_raw;
    pipe_stage_t        cur;
    pipe_stage_t        pipe [PIPE];
    pipe_stage_t        dly;

    logic               req_q;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic               hsync_q;
    logic               vsync_q;
    logic [COLOR_W-1:0] red_q;
    logic [COLOR_W-1:0] green_q;
    logic [COLOR_W-1:0] blue_q;
    logic               frame_start_q;

    assign tick = (div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign v_inc = tick && h_wrap;

    vga_axis_counter #(.WIDTH(H_W), .TOTAL(H_TOT)) u_h_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .inc  (tick),
        .cnt  (h),
        .wrap (h_wrap)
    );

    vga_axis_counter #(.WIDTH(V_W), .TOTAL(V_TOT)) u_v_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .inc  (v_inc),
        .cnt  (v),
        .wrap (v_wrap)
    );

    // Registered origin flag instead of a wide (h==0 && v==0) compare.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            at_origin <= 1'b1;
        end else if (tick) begin
            at_origin <= h_wrap && v_wrap;
        end
    end

    assign active = ({1'b0, h} < H_ACT_END) && ({1'b0, v} < V_ACT_END);
    assign hs_raw = ({1'b0, h} >= HS_START) && ({1'b0, h} < HS_END);
    assign vs_raw = ({1'b0, v} >= VS_START) && ({1'b0, v} < VS_END);
    assign cur    = '{active: active, hs: hs_raw, vs: vs_raw, first: at_origin};
    assign dly    = pipe[PIPE-1];

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            for (int i = 0; i < PIPE; i++) begin
                pipe[i] <= '0;
            end
        end else if (tick) begin
            pipe[0] <= cur;
            for (int i = 1; i < PIPE; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Colour and syncs change only on ticks, from the stage matching the source latency.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            req_q         <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            req_q         <= tick && active;
            frame_start_q <= tick && dly.first;
            if (tick && active) begin
                x_q <= X_W'(h);
                y_q <= Y_W'(v);
            end
            if (tick) begin
                hsync_q <= dly.hs ? HS_POL : ~HS_POL;
                vsync_q <= dly.vs ? VS_POL : ~VS_POL;
                red_q   <= dly.active ? vga.src_r : '0;
                green_q <= dly.active ? vga.src_g : '0;
                blue_q  <= dly.active ? vga.src_b : '0;
            end
        end
    end

    assign vga.pixel_req   = req_q;
    assign vga.pixel_x     = x_q;
    assign vga.pixel_y     = y_q;
    assign vga.HSync       = hsync_q;
    assign vga.VSync       = vsync_q;
    assign vga.RED         = red_q;
    assign vga.GREEN       = green_q;
    assign vga.BLUE        = blue_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_generator.sv
// Runs a default 640x480 instance and a tiny PIPE=3 active-high-sync instance side by side
// against a clock-count raster model, with reset and enable-drop restarts.
module tb_vga_sync_generator;

    typedef struct packed {
        int hact; int hfp; int hsw; int hbp;
        int vact; int vfp; int vsw; int vbp;
        int div;  int pipe; int hpol; int vpol;
    } cfg_t;

    localparam cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1, 0, 0};
    localparam cfg_t CFG_B = '{4, 1, 1, 1, 2, 1, 1, 1, 1, 3, 1, 1};

    typedef struct packed {
        logic        req;
        logic        chk_xy;
        int          x;
        int          y;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic        fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          ka = 0;
    int          kb = 0;
    exp_t        exp_q [$];
    logic [11:0] srcb_pipe [3];
    int          a_hs_low = 0;
    bit          a_seen_req = 1'b0;
    int          b_last_fs = -1;

    vga_sync_generator_if #(.X_W(10), .Y_W(9), .COLOR_W(4)) bus_a ();
    vga_sync_generator_if #(.X_W(2),  .Y_W(1), .COLOR_W(4)) bus_b ();

    vga_sync_generator dut_a (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .vga (bus_a)
    );

    vga_sync_generator #(
        .COLOR_W(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .PIPE(3)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .vga (bus_b)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] color(input int x, input int y);
        logic [3:0] r;
        logic [3:0] g;
        r = 4'(x + 4 * y);
        g = 4'(3 * x + y + 1);
        return {r, g, ~r};
    endfunction

    // k = clock edges since the run started (0 while in reset/idle).
    function automatic exp_t model(input cfg_t c, input int k);
        exp_t e;
        int   ht, vt, t, d, hh, vv;
        ht = c.hact + c.hfp + c.hsw + c.hbp;
        vt = c.vact + c.vfp + c.vsw + c.vbp;
        e = '0;
        e.hs = (c.hpol == 0);
        e.vs = (c.vpol == 0);
        if (k == 0) begin
            e.chk_xy = 1'b1;
            return e;
        end
        if (k % c.div == 0) begin
            t = k / c.div - 1;
            hh = t % ht;
            vv = (t / ht) % vt;
            if (hh < c.hact && vv < c.vact) begin
                e.req = 1'b1;
                e.chk_xy = 1'b1;
                e.x = hh;
                e.y = vv;
            end
        end
        d = k / c.div - 1 - c.pipe;
        if (d >= 0) begin
            hh = d % ht;
            vv = (d / ht) % vt;
            e.rgb = (hh < c.hact && vv < c.vact) ? color(hh, vv) : 12'h000;
            e.hs = ((hh >= c.hact + c.hfp) && (hh < c.hact + c.hfp + c.hsw)) == (c.hpol != 0);
            e.vs = ((vv >= c.vact + c.vfp) && (vv < c.vact + c.vfp + c.vsw)) == (c.vpol != 0);
            e.fs = (k % c.div == 0) && (hh == 0) && (vv == 0);
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic checkDut(input string name, input exp_t e, input logic req, input int x,
                            input int y, input logic hs, input logic vs, input logic [11:0] rgb,
                            input logic fs);
        checkOutput({name, ".pixel_req"}, int'(req), int'(e.req));
        if (e.chk_xy) begin
            checkOutput({name, ".pixel_x"}, x, e.x);
            checkOutput({name, ".pixel_y"}, y, e.y);
        end
        checkOutput({name, ".HSync"}, int'(hs), int'(e.hs));
        checkOutput({name, ".VSync"}, int'(vs), int'(e.vs));
        checkOutput({name, ".rgb"}, int'(rgb), int'(e.rgb));
        checkOutput({name, ".frame_start"}, int'(fs), int'(e.fs));
    endtask

    task automatic trackEvents();
        if (ka == 0) begin
            a_hs_low = 0;
            a_seen_req = 1'b0;
        end else begin
            if (bus_a.HSync == 1'b0) begin
                a_hs_low++;
            end else if (a_hs_low > 0) begin
                checkOutput("a.hsync_width_clk", a_hs_low, 384);
                a_hs_low = 0;
            end
            if (bus_a.pixel_req && !a_seen_req) begin
                checkOutput("a.first_req_latency_clk", ka, 4);
                a_seen_req = 1'b1;
            end
        end
        if (kb == 0) begin
            b_last_fs = -1;
        end else if (bus_b.frame_start) begin
            if (b_last_fs >= 0) begin
                checkOutput("b.frame_period_clk", kb - b_last_fs, 35);
            end
            b_last_fs = kb;
        end
    endtask

    // Pixel sources: A answers with one-tick latency; B is a 3-deep delay line that
    // feeds 4'hF on every slot without a request.
    task automatic driveSources();
        if (bus_a.pixel_req) begin
            {bus_a.src_r, bus_a.src_g, bus_a.src_b} = color(int'(bus_a.pixel_x), int'(bus_a.pixel_y));
        end
        srcb_pipe[2] = srcb_pipe[1];
        srcb_pipe[1] = srcb_pipe[0];
        srcb_pipe[0] = bus_b.pixel_req ? color(int'(bus_b.pixel_x), int'(bus_b.pixel_y)) : 12'hFFF;
        {bus_b.src_r, bus_b.src_g, bus_b.src_b} = srcb_pipe[2];
    endtask

    task automatic applyStimulus(input logic rst_val, input logic en_val, input int cycles);
        exp_t ea;
        exp_t eb;
        for (int i = 0; i < cycles; i++) begin
            rst = rst_val;
            en  = en_val;
            ka = (!rst_val && en_val) ? ka + 1 : 0;
            kb = (!rst_val && en_val) ? kb + 1 : 0;
            exp_q.push_back(model(CFG_A, ka));
            exp_q.push_back(model(CFG_B, kb));
            @(posedge clk);
            @(negedge clk);
            ea = exp_q.pop_front();
            checkDut("a", ea, bus_a.pixel_req, int'(bus_a.pixel_x), int'(bus_a.pixel_y),
                     bus_a.HSync, bus_a.VSync, {bus_a.RED, bus_a.GREEN, bus_a.BLUE},
                     bus_a.frame_start);
            eb = exp_q.pop_front();
            checkDut("b", eb, bus_b.pixel_req, int'(bus_b.pixel_x), int'(bus_b.pixel_y),
                     bus_b.HSync, bus_b.VSync, {bus_b.RED, bus_b.GREEN, bus_b.BLUE},
                     bus_b.frame_start);
            trackEvents();
            driveSources();
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        {bus_a.src_r, bus_a.src_g, bus_a.src_b} = 12'h000;
        for (int i = 0; i < 3; i++) begin
            srcb_pipe[i] = 12'hFFF;
        end
        {bus_b.src_r, bus_b.src_g, bus_b.src_b} = 12'hFFF;
        @(negedge clk);

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 3);

        $display("[TB] run into line 1 of the 640x480 instance");
        applyStimulus(1'b0, 1'b1, 4404);

        $display("[TB] one-clock reset mid-line (h=300, v=1), en held high");
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 3400);

        $display("[TB] en low for 10 clocks mid-line, then restart");
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b1, 3400);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
